// File: rtl/switch_event_scheduler_pkg.sv
// Shared types and constants for the switch event scheduler.
// Defaults target a 25 MHz board: 0.5 s LED on, 0.1 s dark gap.
package switch_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int unsigned DEF_NUM_SW       = 4;
   localparam int unsigned DEF_BLINK_CYCLES = 12500000;
   localparam int unsigned DEF_GAP_CYCLES   = 2500000;

   // Counter must hold the larger of the two interval loads; never narrower than 1 bit.
   function automatic int unsigned cnt_width(int unsigned blink, int unsigned gap);
      int unsigned m;
      m = 2;
      if (blink > m) m = blink;
      if (gap > m) m = gap;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/switch_event_scheduler_if.sv
// Switch/LED bundle between the debounce stage, the scheduler and the board LEDs.
interface switch_event_scheduler_if #(
   parameter int unsigned NUM_SW = 4
);
   localparam int unsigned ID_W = $clog2(NUM_SW);

   logic [NUM_SW-1:0] i_Switch;
   logic [NUM_SW-1:0] o_LED;
   logic              o_Busy;
   logic [ID_W-1:0]   o_Grant_Id;
   logic              o_Drop;

   modport master (
      output i_Switch,
      input  o_LED,
      input  o_Busy,
      input  o_Grant_Id,
      input  o_Drop
   );

   modport slave (
      input  i_Switch,
      output o_LED,
      output o_Busy,
      output o_Grant_Id,
      output o_Drop
   );

endinterface

// File: rtl/switch_event_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from i_Last+1 with wrap.
module rr_arbiter #(
   parameter int unsigned NUM_SW = 4
) (
   input  logic [NUM_SW-1:0]         i_Req,
   input  logic [$clog2(NUM_SW)-1:0] i_Last,
   output logic                      o_Valid,
   output logic [$clog2(NUM_SW)-1:0] o_Next
);
   localparam int unsigned ID_W = $clog2(NUM_SW);

   logic [ID_W-1:0] w_Idx;

   // Walk offsets from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      o_Valid = 1'b0;
      o_Next  = i_Last;
      w_Idx   = '0;
      for (int i = int'(NUM_SW); i >= 1; i--) begin
         w_Idx = ID_W'((int'(i_Last) + i) % int'(NUM_SW));
         if (i_Req[w_Idx]) begin
            o_Valid = 1'b1;
            o_Next  = w_Idx;
         end
      end
   end

endmodule

// File: rtl/switch_event_scheduler.sv
// Turns switch releases into pending events and serves them round-robin on one LED slot:
// LED on for BLINK_CYCLES, then dark for GAP_CYCLES, then one IDLE cycle before the next grant.
module switch_event_scheduler
   import switch_sched_pkg::*;
#(
   parameter int unsigned NUM_SW       = DEF_NUM_SW,
   parameter int unsigned BLINK_CYCLES = DEF_BLINK_CYCLES,
   parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   switch_event_scheduler_if.slave  io_Bus
);
   localparam int unsigned ID_W       = $clog2(NUM_SW);
   localparam int unsigned CNT_W      = cnt_width(BLINK_CYCLES, GAP_CYCLES);
   localparam int unsigned BLINK_LOAD = (BLINK_CYCLES > 0) ? BLINK_CYCLES - 1 : 0;
   localparam int unsigned GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_e            r_State, w_State_Nxt;
   logic [CNT_W-1:0]  r_Cnt, w_Cnt_Nxt;
   logic [ID_W-1:0]   r_Grant_Id, w_Grant_Nxt;
   logic [NUM_SW-1:0] r_LED, w_LED_Nxt;
   logic              r_Busy, w_Busy_Nxt;
   logic [NUM_SW-1:0] r_Prev, r_Pend, w_Pend_Nxt;
   logic              r_Drop, w_Drop_Nxt;

   logic [NUM_SW-1:0] w_Rel, w_Clr, w_Arb_Onehot;
   logic              w_Arb_Valid;
   logic [ID_W-1:0]   w_Arb_Next;

   rr_arbiter #(
      .NUM_SW (NUM_SW)
   ) u_arb (
      .i_Req   (r_Pend),
      .i_Last  (r_Grant_Id),
      .o_Valid (w_Arb_Valid),
      .o_Next  (w_Arb_Next)
   );

   assign w_Rel        = r_Prev & ~io_Bus.i_Switch;
   assign w_Arb_Onehot = NUM_SW'(1) << w_Arb_Next;

   always_comb begin
      w_State_Nxt = r_State;
      w_Cnt_Nxt   = r_Cnt;
      w_Grant_Nxt = r_Grant_Id;
      w_LED_Nxt   = r_LED;
      w_Busy_Nxt  = r_Busy;
      w_Clr       = '0;
      unique case (r_State)
         IDLE: begin
            if (w_Arb_Valid) begin
               w_State_Nxt = SHOW;
               w_Cnt_Nxt   = CNT_W'(BLINK_LOAD);
               w_Grant_Nxt = w_Arb_Next;
               w_Clr       = w_Arb_Onehot;
               w_LED_Nxt   = w_Arb_Onehot;
               w_Busy_Nxt  = 1'b1;
            end
         end
         SHOW: begin
            if (r_Cnt == '0) begin
               w_LED_Nxt = '0;
               if (GAP_CYCLES > 0) begin
                  w_State_Nxt = GAP;
                  w_Cnt_Nxt   = CNT_W'(GAP_LOAD);
               end else begin
                  w_State_Nxt = IDLE;
                  w_Busy_Nxt  = 1'b0;
               end
            end else begin
               w_Cnt_Nxt = r_Cnt - CNT_W'(1);
            end
         end
         GAP: begin
            if (r_Cnt == '0) begin
               w_State_Nxt = IDLE;
               w_Busy_Nxt  = 1'b0;
            end else begin
               w_Cnt_Nxt = r_Cnt - CNT_W'(1);
            end
         end
         default: begin
            w_State_Nxt = IDLE;
            w_LED_Nxt   = '0;
            w_Busy_Nxt  = 1'b0;
         end
      endcase
   end

   // A release on the bit being granted this edge re-pends it and is not a drop.
   assign w_Pend_Nxt = (r_Pend & ~w_Clr) | w_Rel;
   assign w_Drop_Nxt = |(w_Rel & r_Pend & ~w_Clr);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State    <= IDLE;
         r_Cnt      <= '0;
         r_Grant_Id <= ID_W'(NUM_SW - 1);
         r_LED      <= '0;
         r_Busy     <= 1'b0;
         r_Prev     <= '0;
         r_Pend     <= '0;
         r_Drop     <= 1'b0;
      end else begin
         r_State    <= w_State_Nxt;
         r_Cnt      <= w_Cnt_Nxt;
         r_Grant_Id <= w_Grant_Nxt;
         r_LED      <= w_LED_Nxt;
         r_Busy     <= w_Busy_Nxt;
         r_Prev     <= io_Bus.i_Switch;
         r_Pend     <= w_Pend_Nxt;
         r_Drop     <= w_Drop_Nxt;
      end
   end

   assign io_Bus.o_LED      = r_LED;
   assign io_Bus.o_Busy     = r_Busy;
   assign io_Bus.o_Grant_Id = r_Grant_Id;
   assign io_Bus.o_Drop     = r_Drop;

endmodule

// File: tb/tb_switch_event_scheduler.sv
// Bench for switch_event_scheduler: instance A (gap 2) and instance B (gap 0) checked every
// cycle against a timestamp-based model, plus hand-computed literal expectations.
module tb_switch_event_scheduler;

   localparam int BLINK = 8;

   logic clk   = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;

   switch_event_scheduler_if #(.NUM_SW(4)) bus_a ();
   switch_event_scheduler_if #(.NUM_SW(4)) bus_b ();

   switch_event_scheduler #(
      .NUM_SW       (4),
      .BLINK_CYCLES (8),
      .GAP_CYCLES   (2)
   ) u_dut_a (
      .i_Clk   (clk),
      .i_Rst_L (rst_a),
      .io_Bus  (bus_a)
   );

   switch_event_scheduler #(
      .NUM_SW       (4),
      .BLINK_CYCLES (8),
      .GAP_CYCLES   (0)
   ) u_dut_b (
      .i_Clk   (clk),
      .i_Rst_L (rst_b),
      .io_Bus  (bus_b)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int drops_a  = 0;

   // Model state per instance: last grant edge, pending set, last levels, round-robin pointer.
   int         m_g     [2];
   bit         m_has_g [2];
   int         m_gid   [2];
   int         m_gap   [2];
   logic [3:0] m_pend  [2];
   logic [3:0] m_prev  [2];
   logic       m_drop  [2];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset(input int k);
      m_has_g[k] = 1'b0;
      m_g[k]     = 0;
      m_gid[k]   = 3;
      m_pend[k]  = '0;
      m_prev[k]  = '0;
      m_drop[k]  = 1'b0;
   endtask

   task automatic model_step(input int k, input logic [3:0] sw);
      logic [3:0] rel;
      logic [3:0] gbit;
      bit         idle;
      bit         found;
      int         c;
      idle = !m_has_g[k] || (cyc - m_g[k] >= BLINK + m_gap[k] + 1);
      rel  = m_prev[k] & ~sw;
      m_prev[k] = sw;
      gbit  = '0;
      found = 1'b0;
      if (idle && m_pend[k] != 4'b0) begin
         for (int i = 1; i <= 4; i++) begin
            c = (m_gid[k] + i) % 4;
            if (!found && m_pend[k][c]) begin
               found    = 1'b1;
               m_gid[k] = c;
            end
         end
         gbit       = 4'(1 << m_gid[k]);
         m_g[k]     = cyc;
         m_has_g[k] = 1'b1;
      end
      m_drop[k] = |(rel & m_pend[k] & ~gbit);
      m_pend[k] = (m_pend[k] & ~gbit) | rel;
   endtask

   function automatic int exp_led(input int k);
      if (m_has_g[k] && (cyc - m_g[k]) < BLINK) return 1 << m_gid[k];
      return 0;
   endfunction

   function automatic int exp_busy(input int k);
      return (m_has_g[k] && (cyc - m_g[k]) < BLINK + m_gap[k]) ? 1 : 0;
   endfunction

   function automatic logic [3:0] led_of(input int k);
      return (k == 0) ? bus_a.o_LED : bus_b.o_LED;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst_a) model_step(0, bus_a.i_Switch);
      if (rst_b) model_step(1, bus_b.i_Switch);
   end

   always @(negedge rst_a) model_reset(0);
   always @(negedge rst_b) model_reset(1);

   always @(negedge clk) begin
      if (rst_a) begin
         check("a_led",   int'(bus_a.o_LED),      exp_led(0));
         check("a_busy",  int'(bus_a.o_Busy),     exp_busy(0));
         check("a_gid",   int'(bus_a.o_Grant_Id), m_gid[0]);
         check("a_drop",  int'(bus_a.o_Drop),     int'(m_drop[0]));
         if (bus_a.o_Drop) drops_a++;
      end
      if (rst_b) begin
         check("b_led",   int'(bus_b.o_LED),      exp_led(1));
         check("b_busy",  int'(bus_b.o_Busy),     exp_busy(1));
         check("b_gid",   int'(bus_b.o_Grant_Id), m_gid[1]);
         check("b_drop",  int'(bus_b.o_Drop),     int'(m_drop[1]));
      end
   end

   task automatic do_reset_a();
      @(negedge clk);
      rst_a = 1'b0;
      bus_a.i_Switch = 4'b1111;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Drive a one-cycle low on the masked switches so the release is sampled at edge e.
   task automatic rel_at(input int k, input int e, input logic [3:0] m);
      while (cyc < e - 1) @(negedge clk);
      if (k == 0) bus_a.i_Switch = ~m;
      else        bus_b.i_Switch = ~m;
      @(negedge clk);
      if (k == 0) bus_a.i_Switch = 4'b1111;
      else        bus_b.i_Switch = 4'b1111;
   endtask

   task automatic wait_cyc(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic wait_led(input int k, input logic [3:0] v, input int bound,
                           input string name, output int t);
      int n;
      n = 0;
      while (led_of(k) != v && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(led_of(k)), int'(v));
      t = cyc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int k0, t0, t1, t2, d0, lit;
      m_gap[0] = 2;
      m_gap[1] = 0;
      model_reset(0);
      model_reset(1);
      bus_a.i_Switch = 4'b1111;
      bus_b.i_Switch = 4'b1111;

      // Scenario 1: single release on ch2.
      do_reset_a();
      check("rst_led",  int'(bus_a.o_LED), 0);
      check("rst_gid",  int'(bus_a.o_Grant_Id), 3);
      check("rst_busy", int'(bus_a.o_Busy), 0);
      check("rst_drop", int'(bus_a.o_Drop), 0);
      k0 = cyc + 1;
      rel_at(0, k0, 4'b0100);
      check("s1_led_at_rel", int'(bus_a.o_LED), 0);
      @(negedge clk);
      check("s1_led_on",  int'(bus_a.o_LED), 4);
      check("s1_gid",     int'(bus_a.o_Grant_Id), 2);
      check("s1_busy_on", int'(bus_a.o_Busy), 1);
      repeat (7) @(negedge clk);
      check("s1_led_8th", int'(bus_a.o_LED), 4);
      @(negedge clk);
      check("s1_gap_led",  int'(bus_a.o_LED), 0);
      check("s1_gap_busy", int'(bus_a.o_Busy), 1);
      @(negedge clk);
      check("s1_gap2_busy", int'(bus_a.o_Busy), 1);
      @(negedge clk);
      check("s1_idle_busy", int'(bus_a.o_Busy), 0);

      // Scenario 2: ch0, ch1, ch3 released together.
      do_reset_a();
      d0 = drops_a;
      k0 = cyc + 1;
      rel_at(0, k0, 4'b1011);
      wait_led(0, 4'b0001, 20, "s2_ch0", t0);
      wait_led(0, 4'b0010, 20, "s2_ch1", t1);
      wait_led(0, 4'b1000, 20, "s2_ch3", t2);
      check("s2_lat",    t0 - k0, 1);
      check("s2_per01",  t1 - t0, 11);
      check("s2_per13",  t2 - t1, 11);
      repeat (12) @(negedge clk);
      #1;
      check("s2_drops", drops_a - d0, 0);

      // Scenario 3: re-release during SHOW re-pends; a third release before regrant drops.
      do_reset_a();
      d0 = drops_a;
      k0 = cyc + 1;
      rel_at(0, k0, 4'b0010);
      rel_at(0, k0 + 4, 4'b0010);
      #1;
      check("s3_no_drop", drops_a - d0, 0);
      rel_at(0, k0 + 7, 4'b0010);
      @(negedge clk);
      #1;
      check("s3_one_drop", drops_a - d0, 1);
      wait_led(0, 4'b0000, 20, "s3_dark", t0);
      wait_led(0, 4'b0010, 20, "s3_regrant", t1);
      check("s3_period", t1 - (k0 + 1), 11);
      repeat (12) @(negedge clk);
      #1;
      check("s3_drops_total", drops_a - d0, 1);

      // Scenario 4: ch3 released on the very edge it is granted.
      do_reset_a();
      d0 = drops_a;
      k0 = cyc + 2;
      rel_at(0, k0, 4'b0001);
      rel_at(0, k0 + 5, 4'b1000);
      rel_at(0, k0 + 12, 4'b1000);
      #1;
      check("s4_grant3_led", int'(bus_a.o_LED), 8);
      check("s4_grant3_gid", int'(bus_a.o_Grant_Id), 3);
      wait_cyc(k0 + 22);
      #1;
      check("s4_idle_led",  int'(bus_a.o_LED), 0);
      check("s4_idle_busy", int'(bus_a.o_Busy), 0);
      wait_cyc(k0 + 23);
      #1;
      check("s4_regrant3", int'(bus_a.o_LED), 8);
      repeat (11) @(negedge clk);
      #1;
      check("s4_drops", drops_a - d0, 0);

      // Scenario 5: asynchronous reset 3 clocks into SHOW with ch0 and ch2 pending.
      do_reset_a();
      k0 = cyc + 1;
      rel_at(0, k0, 4'b0101);
      rel_at(0, k0 + 2, 4'b0001);
      wait_cyc(k0 + 4);
      check("s5_pre_led", int'(bus_a.o_LED), 1);
      #2;
      rst_a = 1'b0;
      #1;
      check("s5_rst_led",  int'(bus_a.o_LED), 0);
      check("s5_rst_busy", int'(bus_a.o_Busy), 0);
      check("s5_rst_gid",  int'(bus_a.o_Grant_Id), 3);
      @(negedge clk);
      rst_a = 1'b1;
      lit = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (bus_a.o_LED != 4'b0 || bus_a.o_Busy) lit++;
      end
      check("s5_no_grant", lit, 0);
      k0 = cyc + 1;
      rel_at(0, k0, 4'b0100);
      @(negedge clk);
      #1;
      check("s5_new_grant", int'(bus_a.o_LED), 4);
      repeat (12) @(negedge clk);

      // Scenario 6: zero-gap instance, ch0 and ch1 pending.
      @(negedge clk);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      k0 = cyc + 1;
      rel_at(1, k0, 4'b0011);
      wait_led(1, 4'b0001, 10, "s6_ch0", t0);
      wait_led(1, 4'b0010, 20, "s6_ch1", t1);
      check("s6_lat",    t0 - k0, 1);
      check("s6_period", t1 - t0, 9);
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
